// File: rtl/gpio_irq_pkg.sv
// Shared register map, CTRL/IRQ bit positions and decode helper for gpio_irq_ctrl.
// No logic of its own; latency and backpressure not applicable.
package gpio_irq_pkg;

    localparam int ADDR_W = 5;
    localparam int REG_W  = 8;

    localparam logic [ADDR_W-1:0] ADDR_IN_STATE  = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT       = 5'd1;
    localparam logic [ADDR_W-1:0] ADDR_TMR_LOAD  = 5'd2;
    localparam logic [ADDR_W-1:0] ADDR_TMR_COUNT = 5'd3;
    localparam logic [ADDR_W-1:0] ADDR_IN_PEND   = 5'd4;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN   = 5'd5;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN   = 5'd6;
    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 5'd7;

    localparam int CTRL_IN_IE    = 0;
    localparam int CTRL_TMR_IE   = 1;
    localparam int CTRL_AUTO     = 2;
    localparam int CTRL_TMR_PEND = 3;

    localparam int IRQ_IN  = 0;
    localparam int IRQ_TMR = 1;

    function automatic logic wr_hit(input logic we,
                                    input logic [ADDR_W-1:0] waddr,
                                    input logic [ADDR_W-1:0] addr);
        return we && (waddr == addr);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit two-flop synchroniser plus optional debounce (GPIO_IRQ_DEBOUNCE_EN).
// Latency 2 cycles, or 2 + DEBOUNCE_CYCLES with debounce; no backpressure.
module gpio_debounce
`ifdef GPIO_IRQ_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic state_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;

    // Any sample that agrees with the current state restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (sync_q != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
`else
    assign state_o = sync_q;
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO, edge-interrupt and ms countdown timer block; debounce stage under GPIO_IRQ_DEBOUNCE_EN.
// Read data 1 cycle after readaddr, interrupts 1 cycle after pending/enable; no backpressure.
module gpio_irq_ctrl #(
    parameter int NUM_IN          = 8,
    parameter int NUM_OUT         = 4,
    parameter int CLK_KHZ         = 50000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         readaddr,
    output logic [7:0]         readdata,
    input  logic [4:0]         writeaddr,
    input  logic [7:0]         writedata,
    input  logic               write_en,
    output logic [7:0]         interrupts,
    input  logic [NUM_IN-1:0]  pins_in,
    output logic [NUM_OUT-1:0] pins_out
);
    import gpio_irq_pkg::*;

    localparam int PW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_KHZ - 1);

    if (NUM_IN < 1 || NUM_IN > 8 || NUM_OUT < 1 || NUM_OUT > 8 ||
        CLK_KHZ < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("gpio_irq_ctrl: parameter out of range");
    end

    logic [NUM_IN-1:0]  in_state;
    logic [NUM_IN-1:0]  in_prev_q;
    logic [NUM_IN-1:0]  in_evt;
    logic [NUM_IN-1:0]  in_pend_q, in_pend_d;
    logic [NUM_IN-1:0]  rise_en_q;
    logic [NUM_IN-1:0]  fall_en_q;
    logic [NUM_OUT-1:0] out_q;
    logic [7:0]         tmr_load_q;
    logic [7:0]         tmr_cnt_q, tmr_cnt_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [2:0]         ctrl_q;
    logic               tmr_pend_q, tmr_pend_d;
    logic               tmr_set;
    logic               tmr_run;
    logic               ms_tick;
    logic [1:0]         irq_q;
    logic [7:0]         rdata_q, rdata_d;

    logic wr_out, wr_load, wr_pend, wr_rise, wr_fall, wr_ctrl;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
`ifdef GPIO_IRQ_DEBOUNCE_EN
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (pins_in[i]),
            .state_o(in_state[i])
        );
`else
        gpio_debounce u_db (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (pins_in[i]),
            .state_o(in_state[i])
        );
`endif
    end

    assign wr_out  = wr_hit(write_en, writeaddr, ADDR_OUT);
    assign wr_load = wr_hit(write_en, writeaddr, ADDR_TMR_LOAD);
    assign wr_pend = wr_hit(write_en, writeaddr, ADDR_IN_PEND);
    assign wr_rise = wr_hit(write_en, writeaddr, ADDR_RISE_EN);
    assign wr_fall = wr_hit(write_en, writeaddr, ADDR_FALL_EN);
    assign wr_ctrl = wr_hit(write_en, writeaddr, ADDR_CTRL);

    assign in_evt = (in_state & ~in_prev_q & rise_en_q) |
                    (~in_state & in_prev_q & fall_en_q);

    // Clear is applied first so a coincident edge event keeps the bit set.
    always_comb begin
        in_pend_d = in_pend_q;
        if (wr_pend) begin
            in_pend_d = in_pend_d & ~writedata[NUM_IN-1:0];
        end
        in_pend_d = in_pend_d | in_evt;
    end

    assign tmr_run = (tmr_cnt_q != 8'd0);
    assign ms_tick = tmr_run && (pre_q == PRE_TC);

    // A TMR_LOAD write overrides any tick in the same cycle, so no expiry is flagged.
    always_comb begin
        pre_d     = pre_q;
        tmr_cnt_d = tmr_cnt_q;
        tmr_set   = 1'b0;
        if (wr_load) begin
            pre_d     = '0;
            tmr_cnt_d = writedata;
        end else if (tmr_run) begin
            pre_d = ms_tick ? '0 : pre_q + PW'(1);
            if (ms_tick) begin
                if (tmr_cnt_q == 8'd1) begin
                    tmr_set   = 1'b1;
                    tmr_cnt_d = (ctrl_q[CTRL_AUTO] && tmr_load_q != 8'd0) ? tmr_load_q : 8'd0;
                end else begin
                    tmr_cnt_d = tmr_cnt_q - 8'd1;
                end
            end
        end

        tmr_pend_d = tmr_pend_q;
        if (wr_ctrl && writedata[CTRL_TMR_PEND]) begin
            tmr_pend_d = 1'b0;
        end
        if (tmr_set) begin
            tmr_pend_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (readaddr)
            ADDR_IN_STATE:  rdata_d = 8'(in_state);
            ADDR_OUT:       rdata_d = 8'(out_q);
            ADDR_TMR_LOAD:  rdata_d = tmr_load_q;
            ADDR_TMR_COUNT: rdata_d = tmr_cnt_q;
            ADDR_IN_PEND:   rdata_d = 8'(in_pend_q);
            ADDR_RISE_EN:   rdata_d = 8'(rise_en_q);
            ADDR_FALL_EN:   rdata_d = 8'(fall_en_q);
            ADDR_CTRL:      rdata_d = {4'b0000, tmr_pend_q, ctrl_q};
            default:        rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_prev_q  <= '0;
            in_pend_q  <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            out_q      <= '0;
            tmr_load_q <= '0;
            tmr_cnt_q  <= '0;
            pre_q      <= '0;
            ctrl_q     <= '0;
            tmr_pend_q <= 1'b0;
            irq_q      <= '0;
            rdata_q    <= '0;
        end else begin
            in_prev_q  <= in_state;
            in_pend_q  <= in_pend_d;
            if (wr_rise) rise_en_q <= writedata[NUM_IN-1:0];
            if (wr_fall) fall_en_q <= writedata[NUM_IN-1:0];
            if (wr_out)  out_q     <= writedata[NUM_OUT-1:0];
            if (wr_load) tmr_load_q <= writedata;
            if (wr_ctrl) ctrl_q    <= writedata[2:0];
            tmr_cnt_q  <= tmr_cnt_d;
            pre_q      <= pre_d;
            tmr_pend_q <= tmr_pend_d;
            irq_q[IRQ_IN]  <= ctrl_q[CTRL_IN_IE] & (|in_pend_q);
            irq_q[IRQ_TMR] <= ctrl_q[CTRL_TMR_IE] & tmr_pend_q;
            rdata_q    <= rdata_d;
        end
    end

    assign readdata   = rdata_q;
    assign interrupts = {6'b000000, irq_q};
    assign pins_out   = out_q;

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Parametrised memory-mapped GPIO and interrupt controller for the ez8 processor's I/O address space.
- Extends the switch/key/LED block in three ways:
  - N debounced inputs with per-bit rise/fall edge selection and write-1-to-clear pending bits.
  - M outputs.
  - Internal millisecond prescaler with an auto-reload countdown timer.
- Drives the processor's 8-bit `interrupts` vector: bit0 for input events, bit1 for the timer.

Parameters:
- NUM_IN, 8, number of input pins (1..8); register bits at index NUM_IN and above read 0.
- NUM_OUT, 4, number of output pins (1..8).
- CLK_KHZ, 50000, clk frequency in kHz; prescaler terminal count is CLK_KHZ-1.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before the debounced state changes (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- readaddr  in  5  register read address
- readdata  out  8  registered read data
- writeaddr  in  5  register write address
- writedata  in  8  write data
- write_en  in  1  write strobe
- interrupts  out  8  bit0 input IRQ, bit1 timer IRQ, bits 7:2 tied to 0
- pins_in  in  NUM_IN  raw asynchronous inputs (keys, switches)
- pins_out  out  NUM_OUT  output register (LEDs)

Behaviour:
- Register map (unlisted addresses read 0; writes to them are ignored):
  - 0 IN_STATE (RO): debounced input state.
  - 1 OUT (RW): drives pins_out.
  - 2 TMR_LOAD (RW): reload value. A write also loads the counter and restarts the prescaler.
  - 3 TMR_COUNT (RO): current count.
  - 4 IN_PEND (R/W1C): per-input pending bits.
  - 5 RISE_EN (RW): per-input rising-edge enable.
  - 6 FALL_EN (RW): per-input falling-edge enable.
  - 7 CTRL (RW): bit0 input IRQ enable, bit1 timer IRQ enable, bit2 timer auto-reload, bit3 timer pending (W1C).
- Reset: readdata, OUT, TMR_LOAD, count, prescaler, IN_PEND, RISE_EN, FALL_EN, CTRL and debounced state all 0. Outputs are 0.
- Read path: readdata is registered from readaddr, one-cycle latency.
  - A read in the same cycle as a write to the same address returns the pre-write value.
- Input path: two-flop synchroniser, then debounce, then an edge detector on the debounced state.
  - Input-to-IN_STATE latency is 2 + DEBOUNCE_CYCLES cycles.
  - Edge event: rise (0->1 with RISE_EN[i]) or fall (1->0 with FALL_EN[i]).
  - An event sets IN_PEND[i] on the following cycle.
- Pending bits: write 1 clears, write 0 has no effect.
  - A set and a clear in the same cycle: set wins.
- Debounce, per bit: a counter resets whenever the synchronised sample equals the debounced state.
  - The counter increments otherwise.
  - On reaching DEBOUNCE_CYCLES-1 the debounced state flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Prescaler: counts 0..CLK_KHZ-1 and emits a 1-cycle ms_tick at terminal count. It runs only while count != 0.
- Timer, on ms_tick with count != 0:
  - Count decrements.
  - On transition 1->0, timer pending is set.
  - If auto-reload is set and TMR_LOAD != 0, count reloads to TMR_LOAD instead of reaching 0.
- TMR_LOAD write semantics:
  - Writing 0 stops the timer (count=0).
  - A write coincident with ms_tick: the write wins and pending is not set that cycle.
- interrupts[0] = CTRL[0] & |IN_PEND; interrupts[1] = CTRL[1] & CTRL[3]. Both are registered (1 cycle after pending/enable change).
- Reset asserted mid-countdown or mid-debounce aborts immediately. No events are generated on reset release.

Optional Feature:
- Macro GPIO_IRQ_DEBOUNCE_EN.
  - Defined: debounce stage as above.
  - Undefined: debounced state equals the synchroniser output, latency 2 cycles, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared package gpio_irq_pkg:
  - Register address constants ADDR_IN_STATE..ADDR_CTRL.
  - CTRL bit index constants (CTRL_IN_IE=0, CTRL_TMR_IE=1, CTRL_AUTO=2, CTRL_TMR_PEND=3).
  - IRQ bit indices (IRQ_IN=0, IRQ_TMR=1).
- One sub-module, gpio_debounce: single-bit synchroniser plus debounce counter, instantiated NUM_IN times via generate.

Test Plan:
- Reset, then read all addresses 0..31: every readdata = 0x00 one cycle after the address; interrupts = 0x00.
- RISE_EN=0x01, CTRL=0x01, pin0 0->1 held 20 cycles (DEBOUNCE_CYCLES=16):
  - IN_STATE bit0 = 1 after 18 cycles.
  - IN_PEND = 0x01 and interrupts[0] = 1.
  - Write 0x01 to IN_PEND: interrupts[0] drops next cycle.
- Pin1 pulse of 10 cycles with RISE_EN=FALL_EN=0xFF: IN_STATE and IN_PEND unchanged. A 16-cycle pulse sets IN_PEND bit1 once on rise and again after clear on fall.
- CLK_KHZ=4, TMR_LOAD=3, CTRL=0x02: timer pending and interrupts[1] set after 12 cycles; TMR_COUNT reads 0; no further events.
- CTRL=0x06, TMR_LOAD=2: pending sets every 8 cycles.
  - Writing CTRL bit3 with 1 on the same cycle as expiry leaves pending = 1.
  - Writing TMR_LOAD=0 stops the timer.
- Write OUT=0xFF (NUM_OUT=4): pins_out = 0xF, and a read of address 1 returns 0x0F.
